// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory responder: access sizes,
// FSM states and the latency counter width.
package dmem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_RESP = 2'b10
   } state_t;

   // The counter only has to reach LATENCY-1.
   function automatic int cnt_width(input int lat);
      return (lat > 2) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane steering: misalignment detection, store lane placement
// with byte enables, and right-justified load extraction.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   input  logic        load_signed,
   output logic        misalign,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_word,
   output logic [31:0] ld_data
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      misalign = 1'b0;
      wr_be    = 4'b0000;
      wr_word  = 32'h0;
      ld_data  = 32'h0;
      half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
      byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
      case (size)
         SZ_WORD: begin
            misalign = (addr_lo != 2'b00);
            wr_be    = 4'b1111;
            wr_word  = wdata;
            ld_data  = rd_word;
         end
         SZ_HALF: begin
            misalign = addr_lo[0];
            wr_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_word  = {2{wdata[15:0]}};
            ld_data  = {{16{load_signed & half_sel[15]}}, half_sel};
         end
         SZ_BYTE: begin
            wr_be    = 4'b0001 << addr_lo;
            wr_word  = {4{wdata[7:0]}};
            ld_data  = {{24{load_signed & byte_sel[7]}}, byte_sel};
         end
         default: misalign = 1'b1;
      endcase
      // A faulting access never touches memory and returns zero.
      if (misalign) begin
         wr_be   = 4'b0000;
         ld_data = 32'h0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data memory responder with programmable access latency.
// Optional macro DMEM_SIGNED_LOAD_EN adds ReqSigned for sign-extending loads.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
)(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
`ifdef DMEM_SIGNED_LOAD_EN
   input  logic        ReqSigned,
`endif
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] RspData,
   output logic        RspErr,
   output logic        Busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(LATENCY);
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          write_reg;
   logic [1:0]    size_reg;
   logic [AW+1:0] addr_reg;
   logic [31:0]   wdata_reg;
   logic          signed_reg;
   logic [31:0]   rd_word;

   logic          accept, enter_resp;
   logic          sel_write, sel_signed;
   logic [1:0]    sel_size;
   logic [AW+1:0] sel_addr;
   logic [31:0]   sel_wdata;
   logic          misalign;
   logic [3:0]    wr_be;
   logic [31:0]   wr_word, ld_data;

   assign accept = ReqValid && (state_reg == S_IDLE);

   // With single-cycle latency the array is accessed on the accept edge,
   // so the live request fields feed the lane logic while idle.
   assign sel_write  = (state_reg == S_IDLE) ? ReqWrite : write_reg;
   assign sel_size   = (state_reg == S_IDLE) ? ReqSize : size_reg;
   assign sel_addr   = (state_reg == S_IDLE) ? ReqAddr[AW+1:0] : addr_reg;
   assign sel_wdata  = (state_reg == S_IDLE) ? ReqWData : wdata_reg;
`ifdef DMEM_SIGNED_LOAD_EN
   assign sel_signed = (state_reg == S_IDLE) ? ReqSigned : signed_reg;
`else
   assign sel_signed = 1'b0;
`endif

   assign enter_resp = Rst &&
      ((accept && (LATENCY == 1)) || ((state_reg == S_WAIT) && (cnt_reg == CNT_LAST)));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            if (accept) state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               state_next = S_RESP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_RESP: if (RspReady) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         write_reg  <= 1'b0;
         size_reg   <= SZ_WORD;
         addr_reg   <= '0;
         wdata_reg  <= 32'h0;
         signed_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            write_reg  <= ReqWrite;
            size_reg   <= ReqSize;
            addr_reg   <= ReqAddr[AW+1:0];
            wdata_reg  <= ReqWData;
            signed_reg <= sel_signed;
         end
      end
   end

   dmem_lane_align u_align (
      .size        (sel_size),
      .addr_lo     (sel_addr[1:0]),
      .rd_word     (rd_word),
      .wdata       (sel_wdata),
      .load_signed (sel_signed),
      .misalign    (misalign),
      .wr_be       (wr_be),
      .wr_word     (wr_word),
      .ld_data     (ld_data)
   );

   // One byte-wide array per lane gives byte-granular writes without a
   // read-modify-write; contents survive reset.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         logic [7:0] rd_byte_reg;
         always_ff @(posedge Clk) begin
            if (enter_resp) begin
               if (sel_write && wr_be[gi])
                  mem_lane[sel_addr[AW+1:2]] <= wr_word[8*gi +: 8];
               rd_byte_reg <= mem_lane[sel_addr[AW+1:2]];
            end
         end
         assign rd_word[8*gi +: 8] = rd_byte_reg;
      end
   endgenerate

   assign ReqReady = (state_reg == S_IDLE);
   assign Busy     = (state_reg != S_IDLE);
   assign RspValid = (state_reg == S_RESP);
   assign RspErr   = RspValid && misalign;
   assign RspData  = (RspValid && !write_reg) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, LATENCY=2).
// Honours DMEM_SIGNED_LOAD_EN when the design is built with it.
module tb_dmem_responder;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqWrite = 1'b0;
   logic [1:0]  ReqSize = 2'b00;
   logic [31:0] ReqAddr = 32'h0;
   logic [31:0] ReqWData = 32'h0;
   logic        ReqSigned = 1'b0;
   logic        RspValid;
   logic        RspReady = 1'b0;
   logic [31:0] RspData;
   logic        RspErr;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .ReqValid (ReqValid),
      .ReqReady (ReqReady),
      .ReqWrite (ReqWrite),
      .ReqSize  (ReqSize),
      .ReqAddr  (ReqAddr),
      .ReqWData (ReqWData),
`ifdef DMEM_SIGNED_LOAD_EN
      .ReqSigned(ReqSigned),
`endif
      .RspValid (RspValid),
      .RspReady (RspReady),
      .RspData  (RspData),
      .RspErr   (RspErr),
      .Busy     (Busy)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Drives one request and collects its response; lat is -1 on timeout.
   task automatic transact(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] data,
                           output logic err, output int lat);
      int k;
      data = 32'h0;
      err  = 1'b0;
      lat  = -1;
      ReqValid = 1'b1;
      ReqWrite = wr;
      ReqSize  = sz;
      ReqAddr  = addr;
      ReqWData = wdata;
      k = 0;
      while (!ReqReady && k < 20) begin
         tick();
         k++;
      end
      if (!ReqReady) begin
         ReqValid = 1'b0;
         return;
      end
      tick();
      ReqValid = 1'b0;
      ReqWData = 32'hx;
      ReqAddr  = 32'hx;
      k = 0;
      while (!RspValid && k < 20) begin
         tick();
         k++;
      end
      if (RspValid) begin
         lat  = k;
         data = RspData;
         err  = RspErr;
      end
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ReqReady got %0b want 1", ReqReady); end
      checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL reset_RspValid got %0b want 0", RspValid); end
      checks++; if (RspData !== 32'h0) begin errors++; $display("FAIL reset_RspData got %h want 0", RspData); end
      checks++; if (RspErr !== 1'b0) begin errors++; $display("FAIL reset_RspErr got %0b want 0", RspErr); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_Busy got %0b want 0", Busy); end
      $display("reset: ReqReady=%0b RspValid=%0b Busy=%0b", ReqReady, RspValid, Busy);
   endtask

   task automatic test_word();
      logic [31:0] d; logic e; int lat;
      transact(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, d, e, lat);
      $display("store W 0x10 <= deadbeef: lat=%0d data=%h err=%0b", lat, d, e);
      checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat got %0d want 2", lat); end
      checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL word_store_rsp got %h/%0b want 0/0", d, e); end
      transact(1'b0, 2'b00, 32'h10, 32'h0, d, e, lat);
      $display("load W 0x10: lat=%0d data=%h err=%0b", lat, d, e);
      checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat got %0d want 2", lat); end
      checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data got %h want deadbeef", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_load_err got %0b want 0", e); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d; logic e; int lat;
      logic [31:0] half_exp;
      transact(1'b1, 2'b00, 32'h10, 32'h11223344, d, e, lat);
      transact(1'b1, 2'b10, 32'h13, 32'h000000AA, d, e, lat);
      $display("store B 0x13 <= aa: lat=%0d err=%0b", lat, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL byte_store_err got %0b want 0", e); end
      transact(1'b0, 2'b00, 32'h10, 32'h0, d, e, lat);
      $display("load W 0x10: data=%h", d);
      checks++; if (d !== 32'hAA223344) begin errors++; $display("FAIL byte_merge got %h want aa223344", d); end
`ifdef DMEM_SIGNED_LOAD_EN
      ReqSigned = 1'b1;
      half_exp = 32'hFFFFAA22;
`else
      half_exp = 32'h0000AA22;
`endif
      transact(1'b0, 2'b01, 32'h12, 32'h0, d, e, lat);
      ReqSigned = 1'b0;
      $display("load H 0x12: data=%h err=%0b", d, e);
      checks++; if (d !== half_exp) begin errors++; $display("FAIL half_load got %h want %h", d, half_exp); end
      transact(1'b0, 2'b10, 32'h11, 32'h0, d, e, lat);
      $display("load B 0x11: data=%h", d);
      checks++; if (d !== 32'h00000033) begin errors++; $display("FAIL byte_load got %h want 00000033", d); end
   endtask

   task automatic test_errors();
      logic [31:0] d; logic e; int lat;
      transact(1'b1, 2'b00, 32'h00, 32'hCAFEF00D, d, e, lat);
      transact(1'b1, 2'b00, 32'h04, 32'h0BADF00D, d, e, lat);
      transact(1'b0, 2'b00, 32'h02, 32'h0, d, e, lat);
      $display("load W 0x02: lat=%0d data=%h err=%0b", lat, d, e);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_word_load got %h/%0b want 0/1", d, e); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL err_lat got %0d want 2", lat); end
      transact(1'b1, 2'b00, 32'h02, 32'hFFFFFFFF, d, e, lat);
      $display("store W 0x02: err=%0b", e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_word_store got %0b want 1", e); end
      transact(1'b1, 2'b01, 32'h05, 32'hFFFFFFFF, d, e, lat);
      $display("store H 0x05: err=%0b", e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_half_store got %0b want 1", e); end
      transact(1'b0, 2'b01, 32'h05, 32'h0, d, e, lat);
      $display("load H 0x05: data=%h err=%0b", d, e);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_half_load got %h/%0b want 0/1", d, e); end
      transact(1'b1, 2'b11, 32'h00, 32'hFFFFFFFF, d, e, lat);
      $display("store rsvd 0x00: err=%0b", e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_rsvd got %0b want 1", e); end
      transact(1'b0, 2'b00, 32'h00, 32'h0, d, e, lat);
      $display("load W 0x00: data=%h", d);
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL err_mem0 got %h want cafef00d", d); end
      transact(1'b0, 2'b00, 32'h04, 32'h0, d, e, lat);
      $display("load W 0x04: data=%h", d);
      checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL err_mem4 got %h want 0badf00d", d); end
   endtask

   task automatic test_back_to_back();
      int k;
      ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b00; ReqAddr = 32'h10;
      tick();
      // Second request held pending while the first is in flight.
      ReqAddr = 32'h00;
      tick();
      tick();
      checks++; if (RspValid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_lat got %0b want 1", RspValid); end
      for (k = 0; k < 5; k++) begin
         $display("stall cycle %0d: RspValid=%0b RspData=%h ReqReady=%0b", k, RspValid, RspData, ReqReady);
         checks++;
         if (RspValid !== 1'b1 || RspData !== 32'hAA223344 || ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%0b d=%h rdy=%0b want 1/aa223344/0", k, RspValid, RspData, ReqReady);
         end
         tick();
      end
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      $display("after handshake: ReqReady=%0b Busy=%0b RspValid=%0b", ReqReady, Busy, RspValid);
      checks++; if (ReqReady !== 1'b1 || Busy !== 1'b0 || RspValid !== 1'b0) begin
         errors++; $display("FAIL bp_no_accept_on_exit got rdy=%0b busy=%0b v=%0b want 1/0/0", ReqReady, Busy, RspValid);
      end
      tick();
      ReqValid = 1'b0;
      checks++; if (Busy !== 1'b1 || ReqReady !== 1'b0) begin
         errors++; $display("FAIL bp_next_accept got busy=%0b rdy=%0b want 1/0", Busy, ReqReady);
      end
      tick();
      tick();
      $display("second load W 0x00: RspValid=%0b data=%h", RspValid, RspData);
      checks++; if (RspValid !== 1'b1 || RspData !== 32'hCAFEF00D) begin
         errors++; $display("FAIL bp_second_rsp got v=%0b d=%h want 1/cafef00d", RspValid, RspData);
      end
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [31:0] d; logic e; int lat;
      transact(1'b1, 2'b00, 32'h20, 32'h5A5A5A5A, d, e, lat);
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqAddr = 32'h20; ReqWData = 32'h12345678;
      tick();
      ReqValid = 1'b0;
      tick();
      Rst = 1'b0;
      #1;
      $display("abort reset: ReqReady=%0b Busy=%0b RspValid=%0b", ReqReady, Busy, RspValid);
      checks++; if (ReqReady !== 1'b1 || Busy !== 1'b0 || RspValid !== 1'b0 || RspData !== 32'h0) begin
         errors++; $display("FAIL abort_outputs got rdy=%0b busy=%0b v=%0b d=%h want 1/0/0/0", ReqReady, Busy, RspValid, RspData);
      end
      tick();
      tick();
      Rst = 1'b1;
      tick();
      transact(1'b0, 2'b00, 32'h20, 32'h0, d, e, lat);
      $display("load W 0x20 after abort: data=%h", d);
      checks++; if (d !== 32'h5A5A5A5A) begin errors++; $display("FAIL abort_no_write got %h want 5a5a5a5a", d); end
   endtask

   task automatic test_wrap();
      logic [31:0] d; logic e; int lat;
      transact(1'b1, 2'b10, 32'h1000, 32'h00000055, d, e, lat);
      transact(1'b0, 2'b10, 32'h0000, 32'h0, d, e, lat);
      $display("load B 0x0 after store 0x1000: data=%h", d);
      checks++; if (d !== 32'h00000055) begin errors++; $display("FAIL wrap_byte got %h want 00000055", d); end
      transact(1'b0, 2'b00, 32'h0000, 32'h0, d, e, lat);
      $display("load W 0x0: data=%h", d);
      checks++; if (d !== 32'hCAFEF055) begin errors++; $display("FAIL wrap_word got %h want cafef055", d); end
   endtask

   initial begin
      tick();
      tick();
      test_reset();
      Rst = 1'b1;
      tick();
      test_word();
      test_byte_lanes();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipeline's MEM-stage data accesses. It accepts one load/store request at a time over a valid/ready handshake, models a programmable access latency, and performs word, halfword or byte reads and writes on an internal word array. It returns the result over a valid/ready response channel. Busy drives the pipeline stall logic so multi-cycle memories can replace the single-cycle data memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; power of two.
LATENCY, 2, cycles from request accept to RspValid; must be >= 1.

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-low (Rst=0 resets)
ReqValid  in  1  request present
ReqReady  out  1  responder can accept a request
ReqWrite  in  1  1=store, 0=load
ReqSize  in  2  00 word, 01 halfword, 10 byte, 11 reserved
ReqAddr  in  32  byte address
ReqWData  in  32  store data, right-justified
RspValid  out  1  response present
RspReady  in  1  requester takes the response
RspData  out  32  load data, zero-extended; 0 for stores and errors
RspErr  out  1  misaligned access or reserved size
Busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (Rst=0, async): state=IDLE, counter=0. Outputs: ReqReady=1, RspValid=0, RspData=0, RspErr=0, Busy=0. Array contents are not cleared and are preserved across reset.
- FSM states:
  - IDLE -> WAIT on ReqValid&&ReqReady when LATENCY>1.
  - IDLE -> RESP on ReqValid&&ReqReady when LATENCY==1.
  - WAIT -> RESP when counter reaches LATENCY-1.
  - RESP -> IDLE on RspReady.
- ReqReady=1 only in IDLE. Request fields are captured into holding registers at accept; inputs are don't-care afterwards.
- Latency: request accepted at edge T gives RspValid=1 after edge T+LATENCY. RspValid, RspData and RspErr hold stable until RspReady is sampled high. No new request is accepted in the cycle RESP exits; the earliest next accept is one cycle later.
- The array access occurs on the edge entering RESP:
  - Word index = Addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
  - Byte lane = Addr[1:0], little-endian: lane 0 = bits[7:0].
  - Halfword lane = Addr[1]: Addr[1]=0 selects bits[15:0].
  - Store: only the selected byte or halfword lanes are written from ReqWData[7:0] or ReqWData[15:0]. Other lanes are unchanged.
  - Load: the selected lanes are right-justified and zero-extended.
- Error cases (RspErr=1): word access with Addr[1:0]!=0, halfword access with Addr[0]=1, or ReqSize=11. In these cases there is no array write and RspData=0. The response still follows the normal LATENCY timing.
- Reset while in WAIT or RESP: the transaction is aborted, no write occurs, and the pending response is discarded.
- ReqValid held high while not ready: no effect; the request is accepted when the FSM returns to IDLE.

Optional Feature:
DMEM_SIGNED_LOAD_EN
- Defined: adds input port ReqSigned (1 bit), captured at accept. Byte and halfword loads with ReqSigned=1 are sign-extended from bit 7 or bit 15.
- Undefined: the port is absent and all loads zero-extend.
- Stores, word loads and error responses are identical in both builds.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_RSVD=2'b11 (matching the controller's load/store select);
  - state encodings S_IDLE, S_WAIT, S_RESP;
  - the counter width function.
- One sub-module: dmem_lane_align.
  - Combinational block taking size, Addr[1:0], the read word and the store data.
  - Produces the misalign flag, the merged write word and the aligned load data.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
1. LATENCY=2, word store 0xDEADBEEF to 0x10, then word load from 0x10 -> RspValid 2 cycles after each accept, load RspData=0xDEADBEEF, RspErr=0.
2. Byte store 0xAA to 0x13 over word 0x11223344 -> word load of 0x10 returns 0xAA223344. Halfword load of 0x12 returns 0x0000AA22 (0xFFFFAA22 with DMEM_SIGNED_LOAD_EN and ReqSigned=1).
3. Word load at 0x02, halfword load at 0x05, and ReqSize=11 -> each gives RspErr=1 and RspData=0; memory at 0x00 and 0x04 is unchanged.
4. RspReady held low 5 cycles after RspValid -> RspValid, RspData and ReqReady=0 stay stable. A second ReqValid is accepted only in the cycle after the RspReady handshake.
5. Rst pulsed low one cycle after accepting a word store of 0x12345678 to 0x20 -> outputs return to reset values, ReqReady=1 immediately, and a later load of 0x20 returns the old contents.
6. DEPTH=1024: store 0x55 (byte) to 0x1000, then byte load of 0x0000 -> 0x00000055 (wrap-around).
